// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: MIPS fetch stage. Fetches words over a req/ack port, holds the
// instruction for decode and resolves the next PC (JR > J > branch > sequential) on release.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_offset,
    input  logic        jump,
    input  logic [25:0] jump_target,
    input  logic        jr,
    input  logic [31:0] jr_target,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [15:0] inst15_0,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        misalign_err
);
    typedef enum logic {FETCH, VALID} state_t;
    state_t state, state_nx;
    logic [31:0] fetch_pc, next_pc, br_pc;
    logic take_ack, release_inst;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= FETCH;
        else state <= state_nx;

    always_comb
        state_nx = (state == FETCH) ? (imem_ack ? VALID : FETCH) : (stall ? VALID : FETCH);

    always_comb begin
        imem_req = (state == FETCH);
        imem_addr = fetch_pc;
        inst_valid = (state == VALID);
    end

    assign take_ack = (state == FETCH) && imem_ack;
    assign release_inst = (state == VALID) && !stall;
    assign br_pc = pc_plus4 + (branch_offset << 2);
    assign inst15_0 = inst[15:0];

    // Redirects are only consulted when release_inst gates the fetch_pc load.
    always_comb
        next_pc = jr ? {jr_target[31:2], 2'b00} :
                  jump ? {pc_plus4[31:28], jump_target, 2'b00} :
                  branch_taken ? br_pc : pc_plus4;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            fetch_pc <= RESET_PC;
            inst <= '0;
            pc <= RESET_PC;
            pc_plus4 <= RESET_PC + 32'd4;
            misalign_err <= 1'b0;
        end else begin
            if (take_ack) begin
                inst <= imem_rdata;
                pc <= fetch_pc;
                pc_plus4 <= fetch_pc + 32'd4;
            end
            if (release_inst) fetch_pc <= next_pc;
            if (release_inst && jr && (jr_target[1:0] != 2'b00)) misalign_err <= 1'b1;
        end
endmodule
